// File: rtl/msk_and_pipe.sv
// msk_and_pipe: W-lane, d-share domain-oriented masked AND with a
// valid/ready handshake on data, randomness and output. Stage 1 holds the
// refreshed partial products. Share compression is either registered
// (OUT_REG=1, latency 2) or combinational from stage 1 (OUT_REG=0, latency 1).
module msk_and_pipe #(
  parameter int d       = 2,
  parameter int W       = 8,
  parameter bit OUT_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W*d-1:0]           ina,
  input  logic [W*d-1:0]           inb,
  input  logic                     rnd_valid,
  output logic                     rnd_ready,
  input  logic [W*(d*(d-1)/2)-1:0] rnd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W*d-1:0]           out
);
  localparam int N_RND = d*(d-1)/2;
  localparam int NS1   = W*d*d;

  // Offset of the random shared by share pair (i, j) within one lane's slice.
  function automatic int pair_off(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo*d - lo*(lo+1)/2 + (hi-1-lo);
  endfunction

  // Partial products and refresh bits are kept as distinct nets so synthesis
  // cannot merge domains before they are registered.
  (* keep = "true" *) logic [NS1-1:0] prod;
  (* keep = "true" *) logic [NS1-1:0] rfr;
  (* keep = "true" *) logic [NS1-1:0] pp;

  for (genvar k = 0; k < W; k++) begin : g_lane
    for (genvar i = 0; i < d; i++) begin : g_row
      for (genvar j = 0; j < d; j++) begin : g_col
        localparam int IDX = (k*d + i)*d + j;
        assign prod[IDX] = ina[k*d+i] & inb[k*d+j];
        if (i == j) begin : g_diag
          assign rfr[IDX] = 1'b0;
        end else begin : g_pair
          assign rfr[IDX] = rnd[k*N_RND + pair_off(i, j)];
        end
        assign pp[IDX] = prod[IDX] ^ rfr[IDX];
      end
    end
  end

  logic                              fire;
  logic                              adv1;
  logic                              vld_p1;
  (* keep = "true" *) logic [NS1-1:0] s1_p1;
  logic [W*d-1:0]                    xr_p1;

  // A new operation needs both fresh randomness and room in stage 1.
  assign fire      = in_valid & in_ready;
  assign in_ready  = rnd_valid & (~vld_p1 | adv1);
  assign rnd_ready = fire;

  // ---- stage 1 boundary ----
  // Stage-1 valid: set on accept, cleared when the item moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    vld_p1 <= 1'b0;
    else if (fire) vld_p1 <= 1'b1;
    else if (adv1) vld_p1 <= 1'b0;
  end

  // Stage-1 products load only on accept and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    s1_p1 <= '0;
    else if (fire) s1_p1 <= pp;
  end

  // Share compression: output share i is the XOR across row i of stage 1.
  always_comb begin
    xr_p1 = '0;
    for (int k = 0; k < W; k++)
      for (int i = 0; i < d; i++)
        for (int j = 0; j < d; j++)
          xr_p1[k*d+i] = xr_p1[k*d+i] ^ s1_p1[(k*d+i)*d+j];
  end

  // ---- stage 2 boundary ----
  if (OUT_REG) begin : g_oreg
    logic                                vld_p2;
    (* keep = "true" *) logic [W*d-1:0] s2_p2;

    assign adv1      = vld_p1 & (~vld_p2 | out_ready);
    assign out_valid = vld_p2;
    assign out       = s2_p2;

    // Stage-2 valid: filled from stage 1, emptied when downstream accepts.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         vld_p2 <= 1'b0;
      else if (adv1)      vld_p2 <= 1'b1;
      else if (out_ready) vld_p2 <= 1'b0;
    end

    // Stage-2 compressed shares load only when stage 1 advances.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    s2_p2 <= '0;
      else if (adv1) s2_p2 <= xr_p1;
    end
  end else begin : g_ocomb
    assign adv1      = vld_p1 & out_ready;
    assign out_valid = vld_p1;
    assign out       = xr_p1;
  end

endmodule

// File: tb/tb_msk_and_pipe.sv
// Bench for msk_and_pipe: a main d=3/W=8 registered instance with a
// scoreboard, a d=2/W=1 instance for the exact share example and a
// d=4/W=2 combinational-output instance.
module tb_msk_and_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // main instance: d=3, W=8, OUT_REG=1
  logic        a_in_valid, a_in_ready, a_rnd_valid, a_rnd_ready, a_out_valid, a_out_ready;
  logic [23:0] a_ina, a_inb, a_rnd, a_out;

  msk_and_pipe #(.d(3), .W(8), .OUT_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .ina(a_ina), .inb(a_inb), .rnd_valid(a_rnd_valid), .rnd_ready(a_rnd_ready),
    .rnd(a_rnd), .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out)
  );

  // small instance: d=2, W=1, OUT_REG=1
  logic       b_in_valid, b_in_ready, b_rnd_valid, b_rnd_ready, b_out_valid, b_out_ready;
  logic [1:0] b_ina, b_inb, b_out;
  logic [0:0] b_rnd;

  msk_and_pipe #(.d(2), .W(1), .OUT_REG(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ina(b_ina), .inb(b_inb), .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready),
    .rnd(b_rnd), .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out)
  );

  // combinational-output instance: d=4, W=2, OUT_REG=0
  logic        c_in_valid, c_in_ready, c_rnd_valid, c_rnd_ready, c_out_valid, c_out_ready;
  logic [7:0]  c_ina, c_inb, c_out;
  logic [11:0] c_rnd;

  msk_and_pipe #(.d(4), .W(2), .OUT_REG(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .ina(c_ina), .inb(c_inb), .rnd_valid(c_rnd_valid), .rnd_ready(c_rnd_ready),
    .rnd(c_rnd), .out_valid(c_out_valid), .out_ready(c_out_ready), .out(c_out)
  );

  function automatic logic [7:0] unm3(input logic [23:0] x);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = x[3*k] ^ x[3*k+1] ^ x[3*k+2];
    return v;
  endfunction

  function automatic logic [23:0] share3(input logic [7:0] v);
    logic [31:0] r;
    logic [23:0] s;
    r = $urandom;
    for (int k = 0; k < 8; k++) begin
      s[3*k]   = r[2*k];
      s[3*k+1] = r[2*k+1];
      s[3*k+2] = v[k] ^ r[2*k] ^ r[2*k+1];
    end
    return s;
  endfunction

  function automatic logic [1:0] unm4(input logic [7:0] x);
    logic [1:0] v;
    for (int k = 0; k < 2; k++) v[k] = x[4*k] ^ x[4*k+1] ^ x[4*k+2] ^ x[4*k+3];
    return v;
  endfunction

  function automatic logic [7:0] share4(input logic [1:0] v);
    logic [31:0] r;
    logic [7:0]  s;
    r = $urandom;
    for (int k = 0; k < 2; k++) begin
      s[4*k]   = r[3*k];
      s[4*k+1] = r[3*k+1];
      s[4*k+2] = r[3*k+2];
      s[4*k+3] = v[k] ^ r[3*k] ^ r[3*k+1] ^ r[3*k+2];
    end
    return s;
  endfunction

  // Scoreboard for the main instance.
  typedef struct {
    logic [7:0] val;
    int         cyc;
  } sb_t;
  sb_t sbq[$];

  int          cyc        = 0;
  int          npop       = 0;
  bit          exact_lat  = 1'b0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_out   = '0;

  always @(negedge clk) begin
    automatic sb_t e;
    automatic sb_t n;
    cyc <= cyc + 1;
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      check_eq("rnd_ready_is_fire", a_rnd_ready, a_in_valid & a_in_ready);
      if (prev_stall) begin
        check_eq("stall_valid_held", a_out_valid, 1);
        check_eq("stall_out_held", a_out, prev_out);
      end
      if (a_in_valid && a_in_ready) begin
        n.val = unm3(a_ina) & unm3(a_inb);
        n.cyc = cyc;
        sbq.push_back(n);
      end
      if (a_out_valid && a_out_ready) begin
        check_eq("sb_nonempty", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check_eq("sb_data", unm3(a_out), e.val);
          if (exact_lat) check_eq("lat_exact", cyc - e.cyc, 2);
          else           check_eq("lat_min", (cyc - e.cyc) >= 2, 1);
          npop <= npop + 1;
        end
      end
      prev_stall <= a_out_valid & ~a_out_ready;
      prev_out   <= a_out;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          stalls;
    int          base;
    logic [23:0] held;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [1:0]  cv;
    logic [7:0]  c_held;

    rst_n = 1'b0;
    a_in_valid = 0; a_rnd_valid = 1; a_out_ready = 1; a_ina = '0; a_inb = '0; a_rnd = '0;
    b_in_valid = 0; b_rnd_valid = 1; b_out_ready = 1; b_ina = '0; b_inb = '0; b_rnd = '0;
    c_in_valid = 0; c_rnd_valid = 1; c_out_ready = 1; c_ina = '0; c_inb = '0; c_rnd = '0;
    #2;
    check_eq("rst_out_valid", a_out_valid, 0);
    check_eq("rst_out", a_out, 0);
    check_eq("rst_in_ready", a_in_ready, 1);
    check_eq("rst_rnd_ready", a_rnd_ready, 0);
    check_eq("rst_out_valid0", c_out_valid, 0);
    check_eq("rst_out0", c_out, 0);
    check_eq("rst_out2", b_out, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Exact d=2 example: A=1 (01), B=0 (11), r=1.
    b_ina = 2'b01; b_inb = 2'b11; b_rnd = 1'b1; b_in_valid = 1;
    @(negedge clk);
    check_eq("ex_in_ready", b_in_ready, 1);
    check_eq("ex_rnd_ready", b_rnd_ready, 1);
    tick();
    b_in_valid = 0;
    check_eq("ex_valid_c1", b_out_valid, 0);
    check_eq("ex_s1", dut2.s1_p1, 4'b0101);
    tick();
    check_eq("ex_valid_c2", b_out_valid, 1);
    check_eq("ex_out", b_out, 2'b11);
    check_eq("ex_unmasked", b_out[0] ^ b_out[1], 0);
    tick();
    check_eq("ex_drained", b_out_valid, 0);

    // Full-rate stream of 256 random pairs.
    exact_lat = 1'b1;
    stalls = 0;
    base = npop;
    for (int n = 0; n < 256; n++) begin
      ea = 8'($urandom); eb = 8'($urandom);
      a_ina = share3(ea); a_inb = share3(eb); a_rnd = 24'($urandom);
      a_in_valid = 1;
      @(negedge clk);
      if (!a_in_ready) stalls++;
      tick();
    end
    a_in_valid = 0;
    repeat (4) tick();
    exact_lat = 1'b0;
    check_eq("stream_stalls", stalls, 0);
    check_eq("stream_count", npop - base, 256);

    // Back-pressure: fill both stages, stall for 5 cycles, release.
    base = npop;
    a_out_ready = 0;
    for (int n = 0; n < 3; n++) begin
      a_ina = share3(8'($urandom)); a_inb = share3(8'($urandom)); a_rnd = 24'($urandom);
      a_in_valid = 1;
      tick();
    end
    held = a_out;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check_eq("bp_in_ready", a_in_ready, 0);
      check_eq("bp_out_valid", a_out_valid, 1);
      check_eq("bp_out_stable", a_out, held);
      tick();
    end
    a_in_valid = 0;
    a_out_ready = 1;
    repeat (4) tick();
    check_eq("bp_count", npop - base, 2);
    check_eq("bp_sb_empty", sbq.size(), 0);

    // Randomness starvation.
    a_rnd_valid = 0;
    a_ina = share3(8'hA5); a_inb = share3(8'h3C); a_rnd = 24'($urandom);
    a_in_valid = 1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check_eq("starve_in_ready", a_in_ready, 0);
      check_eq("starve_rnd_ready", a_rnd_ready, 0);
      tick();
    end
    a_rnd_valid = 1;
    @(negedge clk);
    check_eq("unstarve_in_ready", a_in_ready, 1);
    check_eq("unstarve_rnd_ready", a_rnd_ready, 1);
    tick();
    a_in_valid = 0;
    @(negedge clk);
    check_eq("idle_rnd_ready", a_rnd_ready, 0);
    repeat (3) tick();
    check_eq("starve_sb_empty", sbq.size(), 0);

    // Reset with two items in flight.
    a_ina = share3(8'hFF); a_inb = share3(8'h0F); a_rnd = 24'($urandom);
    a_in_valid = 1;
    tick();
    a_ina = share3(8'h55); a_inb = share3(8'hF0); a_rnd = 24'($urandom);
    tick();
    a_in_valid = 0;
    check_eq("pre_rst_valid", a_out_valid, 1);
    #1;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    check_eq("async_rst_valid", a_out_valid, 0);
    check_eq("async_rst_out", a_out, 0);
    check_eq("async_rst_rnd_ready", a_rnd_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_no_pulse", a_out_valid, 0);
    ea = 8'h96; eb = 8'h5A;
    a_ina = share3(ea); a_inb = share3(eb); a_rnd = 24'($urandom);
    a_in_valid = 1;
    tick();
    a_in_valid = 0;
    check_eq("post_rst_c1", a_out_valid, 0);
    tick();
    check_eq("post_rst_c2", a_out_valid, 1);
    check_eq("post_rst_data", unm3(a_out), ea & eb);
    repeat (3) tick();
    check_eq("post_rst_sb_empty", sbq.size(), 0);

    // Combinational output, d=4, W=2: latency 1.
    for (int n = 0; n < 4; n++) begin
      cv = (n == 3) ? 2'b01 : 2'b11;
      c_ina = share4(cv); c_inb = share4(2'b11); c_rnd = 12'($urandom);
      c_in_valid = 1;
      @(negedge clk);
      check_eq("c_in_ready", c_in_ready, 1);
      tick();
      c_in_valid = 0;
      check_eq("c_valid_c1", c_out_valid, 1);
      check_eq("c_unmasked", unm4(c_out), cv);
      tick();
      check_eq("c_drained", c_out_valid, 0);
    end

    // Combinational output under back-pressure.
    c_out_ready = 0;
    c_ina = share4(2'b10); c_inb = share4(2'b11); c_rnd = 12'($urandom);
    c_in_valid = 1;
    tick();
    c_ina = share4(2'b01); c_inb = share4(2'b01); c_rnd = 12'($urandom);
    c_held = c_out;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check_eq("c_bp_in_ready", c_in_ready, 0);
      check_eq("c_bp_out", c_out, c_held);
      tick();
    end
    check_eq("c_bp_first", unm4(c_out), 2'b10);
    c_out_ready = 1;
    @(negedge clk);
    check_eq("c_release_in_ready", c_in_ready, 1);
    tick();
    c_in_valid = 0;
    check_eq("c_second_valid", c_out_valid, 1);
    check_eq("c_second", unm4(c_out), 2'b01);
    tick();
    check_eq("c_end_valid", c_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
